pic_fetch_unit: RTL and testbench

Instruction fetch stage for the PIC16F1826-compatible core. Holds the 11-bit program counter and drives the combinational program ROM address. Latches the returned 14-bit word into the instruction register for the execute stage. Owns the 16-level hardware return stack and applies jump, call, return, skip and stall requests from execute, inserting a one-cycle bubble on each control-flow change.

---
 rtl/pic_core_pkg.sv | 19 +
 rtl/pic_return_stack.sv | 53 +++++
 rtl/pic_fetch_unit.sv | 92 +++++++++
 tb/tb_pic_fetch_unit.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/pic_core_pkg.sv
// Shared types and constants for the PIC16F1826-compatible core.
// Imported by the fetch unit and its return stack.
package pic_core_pkg;
   localparam int ADDR_W      = 11;
   localparam int INSN_W      = 14;
   localparam int STACK_DEPTH = 16;
   localparam int SP_W        = $clog2(STACK_DEPTH);

   typedef logic [ADDR_W-1:0] pc_t;
   typedef logic [INSN_W-1:0] insn_t;

   localparam insn_t NOP_WORD = 14'h0000;

   typedef enum logic [1:0] {
      RESET,
      RUN,
      BUBBLE
   } fetch_state_t;
endpackage

// File: rtl/pic_return_stack.sv
// 16-level circular hardware return stack.
// Occupancy count is kept apart from the wrapping index.
module pic_return_stack
   import pic_core_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic push,
   input  logic pop,
   input  pc_t  push_data,
   output pc_t  top,
   output logic ovf,
   output logic unf
);
   localparam logic [SP_W-1:0] SP_ONE  = 1;
   localparam logic [SP_W:0]   CNT_ONE = 1;
   localparam logic [SP_W:0]   FULL    = STACK_DEPTH[SP_W:0];

   logic [SP_W-1:0] sp;
   logic [SP_W:0]   sp_count;
   pc_t             mem [STACK_DEPTH];

   assign top = mem[sp - SP_ONE];

   always_ff @(posedge clk) begin
      if (rst_n && push) begin
         mem[sp] <= push_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sp       <= '0;
         sp_count <= '0;
         ovf      <= 1'b0;
         unf      <= 1'b0;
      end else if (push) begin
         sp <= sp + SP_ONE;
         if (sp_count == FULL) begin
            ovf <= 1'b1;
         end else begin
            sp_count <= sp_count + CNT_ONE;
         end
      end else if (pop) begin
         sp <= sp - SP_ONE;
         if (sp_count == '0) begin
            unf <= 1'b1;
         end else begin
            sp_count <= sp_count - CNT_ONE;
         end
      end
   end
endmodule

// File: rtl/pic_fetch_unit.sv
// Instruction fetch stage: PC, instruction register and fetch FSM.
// Control-flow changes insert exactly one bubble.
module pic_fetch_unit
   import pic_core_pkg::*;
(
   input  logic  clk,
   input  logic  rst_n,
   output pc_t   rom_addr_o,
   input  insn_t rom_data_i,
   input  logic  stall_i,
   input  logic  jump_i,
   input  pc_t   target_i,
   input  logic  push_i,
   input  logic  pop_i,
   input  logic  skip_i,
   output insn_t ir_o,
   output pc_t   ir_pc_o,
   output logic  ir_valid_o,
   output logic  stk_ovf_o,
   output logic  stk_unf_o
);
   fetch_state_t state, state_nx;
   pc_t          pc, pc_nx, ir_pc_nx, stk_top;
   insn_t        ir_nx;
   logic         valid_nx;
   logic         live, do_pop, do_jump, do_skip;

   assign rom_addr_o = pc;

   // Requests only count when a real instruction sits in IR.
   assign live    = (state == RUN) && !stall_i;
   assign do_pop  = live && pop_i;
   assign do_jump = live && !pop_i && jump_i;
   assign do_skip = live && !pop_i && !jump_i && skip_i;

   pic_return_stack u_stack (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (do_jump && push_i),
      .pop       (do_pop),
      .push_data (pc),
      .top       (stk_top),
      .ovf       (stk_ovf_o),
      .unf       (stk_unf_o)
   );

   always_comb begin
      state_nx = state;
      pc_nx    = pc;
      ir_nx    = ir_o;
      ir_pc_nx = ir_pc_o;
      valid_nx = ir_valid_o;
      unique case (1'b1)
         stall_i: begin
         end
         do_pop, do_jump, do_skip: begin
            unique case (1'b1)
               do_pop:  pc_nx = stk_top;
               do_jump: pc_nx = target_i;
               default: pc_nx = pc + pc_t'(1);
            endcase
            ir_nx    = NOP_WORD;
            ir_pc_nx = pc;
            valid_nx = 1'b0;
            state_nx = BUBBLE;
         end
         default: begin
            pc_nx    = pc + pc_t'(1);
            ir_nx    = rom_data_i;
            ir_pc_nx = pc;
            valid_nx = 1'b1;
            state_nx = RUN;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= RESET;
         pc         <= '0;
         ir_o       <= NOP_WORD;
         ir_pc_o    <= '0;
         ir_valid_o <= 1'b0;
      end else begin
         state      <= state_nx;
         pc         <= pc_nx;
         ir_o       <= ir_nx;
         ir_pc_o    <= ir_pc_nx;
         ir_valid_o <= valid_nx;
      end
   end
endmodule

// File: tb/tb_pic_fetch_unit.sv
// Self-checking bench for pic_fetch_unit.
// Reference model feeds a scoreboard; directed checks cover key cases.
module tb_pic_fetch_unit;
   logic        clk = 1'b0;
   logic        rst_n, stall_i, jump_i, push_i, pop_i, skip_i;
   logic [10:0] target_i, rom_addr_o, ir_pc_o;
   logic [13:0] rom_data_i, ir_o;
   logic        ir_valid_o, stk_ovf_o, stk_unf_o;

   logic [13:0] rom [2048];
   assign rom_data_i = rom[rom_addr_o];

   always #5 clk = ~clk;

   pic_fetch_unit dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .rom_addr_o (rom_addr_o),
      .rom_data_i (rom_data_i),
      .stall_i    (stall_i),
      .jump_i     (jump_i),
      .target_i   (target_i),
      .push_i     (push_i),
      .pop_i      (pop_i),
      .skip_i     (skip_i),
      .ir_o       (ir_o),
      .ir_pc_o    (ir_pc_o),
      .ir_valid_o (ir_valid_o),
      .stk_ovf_o  (stk_ovf_o),
      .stk_unf_o  (stk_unf_o)
   );

   typedef struct {
      logic [10:0] pc;
      logic [13:0] ir;
      logic [10:0] irpc;
      logic        v;
      logic        ovf;
      logic        unf;
   } exp_t;

   exp_t sb [$];
   int total = 0;
   int bad   = 0;

   logic [10:0] m_pc, m_irpc;
   logic [13:0] m_ir;
   logic        m_v, m_ovf, m_unf;
   logic [3:0]  m_sp;
   int          m_cnt, m_st;
   logic [10:0] m_stk [16];

   task automatic chk(input string tag, input logic [15:0] got,
                      input logic [15:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", tag, got, exp);
      end
   endtask

   task automatic step(input logic r, input logic s, input logic j,
                       input logic [10:0] t, input logic pu,
                       input logic po, input logic sk);
      logic [10:0] opc;
      logic        bub;
      exp_t        e;
      opc = m_pc;
      bub = 1'b0;
      rst_n = r; stall_i = s; jump_i = j; target_i = t;
      push_i = pu; pop_i = po; skip_i = sk;
      if (!r) begin
         m_pc = 0; m_ir = 0; m_irpc = 0; m_v = 0;
         m_sp = 0; m_cnt = 0; m_ovf = 0; m_unf = 0; m_st = 0;
      end else if (s) begin
      end else if (m_st == 1 && po) begin
         m_sp = m_sp - 4'd1;
         m_pc = m_stk[m_sp];
         if (m_cnt == 0) m_unf = 1; else m_cnt--;
         bub = 1'b1;
      end else if (m_st == 1 && j) begin
         if (pu) begin
            m_stk[m_sp] = opc;
            m_sp = m_sp + 4'd1;
            if (m_cnt == 16) m_ovf = 1; else m_cnt++;
         end
         m_pc = t;
         bub = 1'b1;
      end else if (m_st == 1 && sk) begin
         m_pc = opc + 11'd1;
         bub = 1'b1;
      end else begin
         m_ir = rom[opc]; m_irpc = opc; m_v = 1;
         m_pc = opc + 11'd1; m_st = 1;
      end
      if (bub) begin
         m_ir = 0; m_v = 0; m_irpc = opc; m_st = 2;
      end
      e = '{m_pc, m_ir, m_irpc, m_v, m_ovf, m_unf};
      sb.push_back(e);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         total++; bad++;
         $display("FAIL sb_empty: got 0 entries want 1");
      end else begin
         e = sb.pop_front();
         chk("sb_pc",   16'(rom_addr_o), 16'(e.pc));
         chk("sb_ir",   16'(ir_o),       16'(e.ir));
         chk("sb_irpc", 16'(ir_pc_o),    16'(e.irpc));
         chk("sb_v",    16'(ir_valid_o), 16'(e.v));
         chk("sb_ovf",  16'(stk_ovf_o),  16'(e.ovf));
         chk("sb_unf",  16'(stk_unf_o),  16'(e.unf));
      end
   endtask

   task automatic nrm();
      step(1, 0, 0, 11'h0, 0, 0, 0);
   endtask

   task automatic call(input logic [10:0] t);
      step(1, 0, 1, t, 1, 0, 0);
   endtask

   task automatic ret();
      step(1, 0, 0, 11'h0, 0, 1, 0);
   endtask

   initial begin
      logic [10:0] saved;
      for (int i = 0; i < 2048; i++) rom[i] = 14'((i * 13 + 7) ^ (i << 3));
      rom[0] = 14'h01A3; rom[6] = 14'h1E91;
      rom[7] = 14'h2806; rom[21] = 14'h0AA5;
      for (int i = 0; i < 16; i++) m_stk[i] = '0;
      m_pc = 0; m_st = 0; m_sp = 0; m_cnt = 0;

      step(0, 0, 0, 11'h0, 0, 0, 0);
      step(0, 0, 0, 11'h0, 0, 0, 0);
      chk("rst_addr",  16'(rom_addr_o), 16'h0);
      chk("rst_valid", 16'(ir_valid_o), 16'h0);
      chk("rst_ir",    16'(ir_o),       16'h0);

      nrm();
      chk("f1_ir",   16'(ir_o),       16'h01A3);
      chk("f1_irpc", 16'(ir_pc_o),    16'h0);
      chk("f1_v",    16'(ir_valid_o), 16'h1);
      chk("f1_pc",   16'(rom_addr_o), 16'h1);
      repeat (7) nrm();
      chk("j_pre_ir", 16'(ir_o), 16'h2806);

      step(1, 0, 1, 11'h006, 0, 0, 0);
      chk("j_bub_v", 16'(ir_valid_o), 16'h0);
      chk("j_pc",    16'(rom_addr_o), 16'h006);
      nrm();
      chk("j_ir",   16'(ir_o),    16'h1E91);
      chk("j_irpc", 16'(ir_pc_o), 16'h006);

      repeat (10) nrm();
      chk("c_pre_pc", 16'(rom_addr_o), 16'h011);
      call(11'h020);
      chk("c_pc",  16'(rom_addr_o), 16'h020);
      chk("c_cnt", 16'(dut.u_stack.sp_count), 16'h1);
      nrm();
      ret();
      chk("r_pc",  16'(rom_addr_o), 16'h011);
      chk("r_cnt", 16'(dut.u_stack.sp_count), 16'h0);

      repeat (3) nrm();
      step(1, 0, 0, 11'h0, 0, 0, 1);
      chk("s_ir",   16'(ir_o),       16'h0);
      chk("s_v",    16'(ir_valid_o), 16'h0);
      chk("s_irpc", 16'(ir_pc_o),    16'h014);
      nrm();
      chk("s_next_ir",   16'(ir_o),    16'h0AA5);
      chk("s_next_irpc", 16'(ir_pc_o), 16'h015);

      for (int i = 0; i < 17; i++) begin
         call(11'(12'h100 + i * 4));
         if (i == 15) chk("ovf16", 16'(stk_ovf_o), 16'h0);
         if (i == 16) chk("ovf17", 16'(stk_ovf_o), 16'h1);
         nrm();
      end
      for (int i = 0; i < 17; i++) begin
         ret();
         if (i == 15) begin
            chk("unf16", 16'(stk_unf_o), 16'h0);
            chk("cnt0",  16'(dut.u_stack.sp_count), 16'h0);
         end
         if (i == 16) chk("unf17", 16'(stk_unf_o), 16'h1);
         nrm();
      end

      saved = m_pc;
      call(11'h300);
      nrm();
      step(1, 0, 1, 11'h3FF, 0, 1, 0);
      chk("popwins", 16'(rom_addr_o), 16'(saved));
      nrm();
      step(1, 0, 0, 11'h0, 1, 0, 0);
      step(1, 0, 1, 11'h500, 0, 0, 0);
      step(1, 0, 1, 11'h600, 0, 0, 0);
      chk("bub_ign", 16'(rom_addr_o), 16'h501);

      step(1, 0, 1, 11'h7FE, 0, 0, 0);
      nrm();
      nrm();
      chk("wrap_pc",   16'(rom_addr_o), 16'h0);
      chk("wrap_irpc", 16'(ir_pc_o),    16'h7FF);

      for (int i = 0; i < 300; i++) begin
         step(1, $urandom_range(0, 5) == 0, $urandom_range(0, 3) == 0,
              11'($urandom), $urandom_range(0, 1) == 0,
              $urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0);
      end

      nrm();
      nrm();
      saved = m_pc;
      repeat (3) step(1, 1, 1, 11'h123, 0, 0, 1);
      chk("stall_pc", 16'(rom_addr_o), 16'(saved));
      step(0, 1, 1, 11'h123, 0, 0, 0);
      chk("rst2_pc",  16'(rom_addr_o), 16'h0);
      chk("rst2_v",   16'(ir_valid_o), 16'h0);
      chk("rst2_ovf", 16'(stk_ovf_o),  16'h0);
      chk("rst2_unf", 16'(stk_unf_o),  16'h0);
      chk("rst2_cnt", 16'(dut.u_stack.sp_count), 16'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
